// File: rtl/i2c_reg_sequencer_if.sv
// Client request/response and i2c_master byte-command bundle for i2c_reg_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface i2c_reg_sequencer_if;
  localparam int unsigned C_SZ = 6;
  localparam int unsigned S_SZ = 3;

  logic            req_valid;
  logic            req_ready;
  logic            req_rd;
  logic [6:0]      req_dev;
  logic [7:0]      req_reg;
  logic [7:0]      req_wdat;
  logic            rsp_valid;
  logic [7:0]      rsp_rdat;
  logic [1:0]      rsp_err;
  logic            busy;
  logic [C_SZ-1:0] mst_cmd;
  logic [7:0]      mst_dat;
  logic            mst_ws;
  logic [S_SZ-1:0] mst_stat;
  logic [7:0]      mst_dat_in;

  modport slave (
    input  req_valid, req_rd, req_dev, req_reg, req_wdat, mst_stat, mst_dat_in,
    output req_ready, rsp_valid, rsp_rdat, rsp_err, busy, mst_cmd, mst_dat, mst_ws
  );

  modport master (
    output req_valid, req_rd, req_dev, req_reg, req_wdat, mst_stat, mst_dat_in,
    input  req_ready, rsp_valid, rsp_rdat, rsp_err, busy, mst_cmd, mst_dat, mst_ws
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Expands one register read/write request into the i2c_master strobe sequence,
// maps master errors to a response code, then clears errors and releases the bus.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic                clk,
  input logic                rst,
  i2c_reg_sequencer_if.slave bus
);
  localparam int unsigned C_SZ   = 6;
  localparam int unsigned C_STRT = 0;
  localparam int unsigned C_STOP = 1;
  localparam int unsigned C_READ = 2;
  localparam int unsigned C_WRTE = 3;
  localparam int unsigned C_NACK = 4;
  localparam int unsigned C_CLRS = 5;
  localparam int unsigned SB_DON = 0;
  localparam int unsigned SB_ERR = 1;
  localparam int unsigned SB_BBY = 2;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_CLR, S_CLR_ARM, S_CLR_WAIT,
    S_STOP, S_STOP_ARM, S_STOP_WAIT, S_RSP
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic            rd_q, rd_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdat_q, wdat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      rdat_q, rdat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [C_SZ-1:0] cmd_q, cmd_d;
  logic [7:0]      dat_q, dat_d;
  logic            ws_q, ws_d;
  logic            clr_once_q, clr_once_d;

  logic            timed_out_c;
  logic            last_step_c;
  logic [C_SZ+7:0] first_c;
  logic [C_SZ+7:0] next_c;

  // Step table: {cmd, dat} for a given step of a read or write
  function automatic logic [C_SZ+7:0] step_cmd(input logic [1:0] step, input logic rd,
                                               input logic [6:0] dev, input logic [7:0] rg,
                                               input logic [7:0] wd);
    logic [C_SZ-1:0] c;
    logic [7:0]      d;
    c = '0;
    d = '0;
    case (step)
      2'd0: begin c[C_STRT] = 1'b1; c[C_WRTE] = 1'b1; d = {dev, 1'b0}; end
      2'd1: begin c[C_WRTE] = 1'b1; d = rg; end
      2'd2: begin
        if (rd) begin c[C_STRT] = 1'b1; c[C_WRTE] = 1'b1; d = {dev, 1'b1}; end
        else    begin c[C_WRTE] = 1'b1; c[C_STOP] = 1'b1; d = wd; end
      end
      default: begin c[C_READ] = 1'b1; c[C_NACK] = 1'b1; c[C_STOP] = 1'b1; end
    endcase
    return {c, d};
  endfunction

  assign timed_out_c = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
  assign last_step_c = rd_q ? (step_q == 2'd3) : (step_q == 2'd2);
  assign first_c     = step_cmd(2'd0, bus.req_rd, bus.req_dev, bus.req_reg, bus.req_wdat);
  assign next_c      = step_cmd(step_q + 2'd1, rd_q, dev_q, reg_q, wdat_q);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rd_d        = rd_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdat_d      = wdat_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    err_d       = err_q;
    rdat_d      = rdat_q;
    cmd_d       = cmd_q;
    dat_d       = dat_q;
    ws_d        = 1'b0;
    clr_once_d  = clr_once_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          rd_d           = bus.req_rd;
          dev_d          = bus.req_dev;
          reg_d          = bus.req_reg;
          wdat_d         = bus.req_wdat;
          step_d         = 2'd0;
          err_d          = 2'd0;
          rdat_d         = 8'd0;
          clr_once_d     = 1'b0;
          {cmd_d, dat_d} = first_c;
          ws_d           = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ARM;
      // Status lags the strobe by a cycle, so it is not looked at here
      S_ARM: begin cnt_d = '0; state_d = S_WAIT; end
      S_WAIT: begin
        if (bus.mst_stat[SB_ERR]) begin
          err_d = ((step_q == 2'd0) || (rd_q && step_q == 2'd2)) ? 2'd1 : 2'd2;
          cmd_d = C_SZ'(1) << C_CLRS;
          dat_d = 8'd0;
          ws_d  = 1'b1;
          state_d = S_CLR;
        end else if (bus.mst_stat[SB_DON]) begin
          if (last_step_c) begin
            if (rd_q) rdat_d = bus.mst_dat_in;
            state_d = S_RSP;
          end else begin
            step_d         = step_q + 2'd1;
            {cmd_d, dat_d} = next_c;
            ws_d           = 1'b1;
            state_d        = S_ISSUE;
          end
        end else if (timed_out_c) begin
          err_d = 2'd3;
          cmd_d = C_SZ'(1) << C_CLRS;
          dat_d = 8'd0;
          ws_d  = 1'b1;
          state_d = S_CLR;
        end
      end
      S_CLR:     state_d = S_CLR_ARM;
      S_CLR_ARM: begin cnt_d = '0; state_d = S_CLR_WAIT; end
      // Recovery: release a still-held bus with STOP, unless this clear followed a STOP error
      S_CLR_WAIT: begin
        if (bus.mst_stat[SB_DON]) begin
          if (bus.mst_stat[SB_BBY] && !clr_once_q) begin
            cmd_d   = C_SZ'(1) << C_STOP;
            dat_d   = 8'd0;
            ws_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = S_RSP;
          end
        end else if (timed_out_c) begin
          state_d = S_RSP;
        end
      end
      S_STOP:     state_d = S_STOP_ARM;
      S_STOP_ARM: begin cnt_d = '0; state_d = S_STOP_WAIT; end
      S_STOP_WAIT: begin
        if (bus.mst_stat[SB_ERR] && !clr_once_q) begin
          clr_once_d = 1'b1;
          cmd_d      = C_SZ'(1) << C_CLRS;
          dat_d      = 8'd0;
          ws_d       = 1'b1;
          state_d    = S_CLR;
        end else if (bus.mst_stat[SB_DON] || timed_out_c) begin
          state_d = S_RSP;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RSP);
    ready_d     = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 2'd0;
      rd_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wdat_q      <= 8'd0;
      cnt_q       <= '0;
      err_q       <= 2'd0;
      rdat_q      <= 8'd0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      cmd_q       <= '0;
      dat_q       <= 8'd0;
      ws_q        <= 1'b0;
      clr_once_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rd_q        <= rd_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdat_q      <= wdat_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdat_q      <= rdat_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      cmd_q       <= cmd_d;
      dat_q       <= dat_d;
      ws_q        <= ws_d;
      clr_once_q  <= clr_once_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdat  = rdat_q;
  assign bus.rsp_err   = err_q;
  assign bus.mst_cmd   = cmd_q;
  assign bus.mst_dat   = dat_q;
  assign bus.mst_ws    = ws_q;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer against a behavioural i2c_master stand-in
// with one attached register-RAM slave at address 0x3a.
module tb_i2c_reg_sequencer;
  localparam int unsigned TO = 5000;
  localparam logic [6:0] DEV = 7'h3a;
  localparam logic [5:0] K_STRT = 6'h01;
  localparam logic [5:0] K_STOP = 6'h02;
  localparam logic [5:0] K_READ = 6'h04;
  localparam logic [5:0] K_WRTE = 6'h08;
  localparam logic [5:0] K_NACK = 6'h10;
  localparam logic [5:0] K_CLRS = 6'h20;
  localparam logic [5:0] K_SW   = K_STRT | K_WRTE;
  localparam logic [5:0] K_WS   = K_WRTE | K_STOP;
  localparam logic [5:0] K_RNS  = K_READ | K_NACK | K_STOP;

  typedef struct {
    int          tid;
    logic [7:0]  rdat;
    logic [1:0]  err;
    int          nws;
    logic [47:0] sig;
    int          acc_cyc;
    int          lat_min;
    int          lat_max;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_reg_sequencer_if bus();
  i2c_reg_sequencer #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rsp_cyc = 0;
  exp_t exp_q[$];
  bit   hang_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int tid, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL t%0d %s: got 0x%0h expected 0x%0h", tid, name, act, exp);
    end
  endtask

  // Behavioural i2c_master: one-cycle command latency, slave RAM at DEV
  logic       st_don, st_err, st_bby;
  logic [7:0] st_din;
  logic       p_err, p_bby;
  logic [7:0] p_din;
  logic [1:0] lat;
  logic       phase;
  logic [7:0] ptr;
  logic [7:0] ram [256];

  assign bus.mst_stat   = {st_bby, st_err, st_don};
  assign bus.mst_dat_in = st_din;

  always @(posedge clk) begin
    if (rst) begin
      st_don <= 1'b0; st_err <= 1'b0; st_bby <= 1'b0; st_din <= 8'd0;
      p_err  <= 1'b0; p_bby  <= 1'b0; p_din  <= 8'd0; lat    <= 2'd0; phase <= 1'b0;
    end else if (bus.mst_ws) begin
      st_don <= 1'b0;
      lat    <= 2'd1;
      if ((bus.mst_cmd & K_CLRS) != 0) begin
        p_err <= 1'b0;
      end else begin
        if ((bus.mst_cmd & K_STRT) != 0) begin
          p_bby <= 1'b1;
          phase <= 1'b0;
          if (hang_en) lat <= 2'd0;
          else if (bus.mst_dat[7:1] != DEV) p_err <= 1'b1;
        end else if ((bus.mst_cmd & K_WRTE) != 0) begin
          if (!phase) begin ptr <= bus.mst_dat; phase <= 1'b1; end
          else begin ram[ptr] <= bus.mst_dat; ptr <= ptr + 8'd1; end
        end
        if ((bus.mst_cmd & K_READ) != 0) begin p_din <= ram[ptr]; ptr <= ptr + 8'd1; end
        if ((bus.mst_cmd & K_STOP) != 0) p_bby <= 1'b0;
      end
    end else if (lat != 2'd0) begin
      lat <= lat - 2'd1;
      if (lat == 2'd1) begin
        st_don <= 1'b1; st_err <= p_err; st_bby <= p_bby; st_din <= p_din;
      end
    end
  end

  // Monitor: counts strobes per transaction and scores each response
  initial begin
    int          nws;
    logic [47:0] sig;
    int          strobe_cyc;
    logic        prev_ws;
    exp_t        e;
    nws = 0; sig = '0; strobe_cyc = 0; prev_ws = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nws = 0; sig = '0; prev_ws = 1'b0;
      end else begin
        if (bus.mst_ws) begin
          if (nws == 0) strobe_cyc = cyc;
          nws++;
          sig = {sig[41:0], bus.mst_cmd};
          chk(0, "ws_single_cycle", 64'(prev_ws), 64'(0));
        end
        prev_ws = bus.mst_ws;
        if (bus.rsp_valid) begin
          last_rsp_cyc = cyc;
          chk(0, "rsp_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.tid, "rsp_err", 64'(bus.rsp_err), 64'(e.err));
            chk(e.tid, "rsp_rdat", 64'(bus.rsp_rdat), 64'(e.rdat));
            chk(e.tid, "ws_count", 64'(nws), 64'(e.nws));
            chk(e.tid, "cmd_sequence", 64'(sig), 64'(e.sig));
            chk(e.tid, "first_strobe_lat", 64'(strobe_cyc - e.acc_cyc), 64'(1));
            chk(e.tid, "bus_idle_after", 64'(st_bby), 64'(0));
            if (e.lat_max != 0)
              chk(e.tid, "timeout_window",
                  64'((cyc - strobe_cyc >= e.lat_min) && (cyc - strobe_cyc <= e.lat_max)), 64'(1));
          end
          nws = 0; sig = '0;
        end
      end
    end
  end

  function automatic exp_t mk(input int tid, input logic [7:0] rdat, input logic [1:0] err,
                              input int nws, input logic [47:0] sig);
    exp_t e;
    e.tid = tid; e.rdat = rdat; e.err = err; e.nws = nws; e.sig = sig;
    e.acc_cyc = 0; e.lat_min = 0; e.lat_max = 0;
    return e;
  endfunction

  task automatic send(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [7:0] wd, input exp_t e, input bit push, input bit hold,
                      input bit b2b);
    int   n;
    exp_t ec;
    ec = e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rd    = rd;
    bus.req_dev   = dev;
    bus.req_reg   = rg;
    bus.req_wdat  = wd;
    n = 0;
    while (!bus.req_ready && n < 20000) begin @(negedge clk); n++; end
    chk(e.tid, "accept", 64'(bus.req_ready), 64'(1));
    if (!bus.req_ready) begin bus.req_valid = 1'b0; return; end
    if (b2b) chk(e.tid, "accept_after_rsp", 64'(cyc - last_rsp_cyc), 64'(1));
    ec.acc_cyc = cyc;
    if (push) exp_q.push_back(ec);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int tid);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    chk(tid, "drain_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input int tid);
    chk(tid, "rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk(tid, "rst_busy", 64'(bus.busy), 64'(0));
    chk(tid, "rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk(tid, "rst_rsp_rdat", 64'(bus.rsp_rdat), 64'(0));
    chk(tid, "rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk(tid, "rst_mst_cmd", 64'(bus.mst_cmd), 64'(0));
    chk(tid, "rst_mst_dat", 64'(bus.mst_dat), 64'(0));
    chk(tid, "rst_mst_ws", 64'(bus.mst_ws), 64'(0));
  endtask

  initial begin
    exp_t e;
    int   n;
    bus.req_valid = 1'b0;
    bus.req_rd    = 1'b0;
    bus.req_dev   = 7'd0;
    bus.req_reg   = 8'd0;
    bus.req_wdat  = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset(0);
    rst = 1'b0;

    // T1 write, T2 read-back
    send(1'b0, DEV, 8'h00, 8'h11, mk(1, 8'h00, 2'd0, 3, 48'({K_SW, K_WRTE, K_WS})), 1'b1, 1'b0, 1'b0);
    drain(1);
    send(1'b1, DEV, 8'h00, 8'h00, mk(2, 8'h11, 2'd0, 4, 48'({K_SW, K_WRTE, K_SW, K_RNS})), 1'b1, 1'b0, 1'b0);
    drain(2);

    // T3 absent device: address NAK, clear, then STOP
    send(1'b0, 7'h20, 8'h00, 8'h55, mk(3, 8'h00, 2'd1, 3, 48'({K_SW, K_CLRS, K_STOP})), 1'b1, 1'b0, 1'b0);
    drain(3);

    // T4 clock stretched forever on the address byte
    hang_en = 1'b1;
    e = mk(4, 8'h00, 2'd3, 3, 48'({K_SW, K_CLRS, K_STOP}));
    e.lat_min = TO;
    e.lat_max = TO + 10;
    send(1'b0, DEV, 8'h01, 8'h22, e, 1'b1, 1'b0, 1'b0);
    drain(4);
    hang_en = 1'b0;

    // T5 reset while the repeated-start strobe of a read is on the bus
    send(1'b1, DEV, 8'h00, 8'h00, mk(5, 8'h00, 2'd0, 0, 48'd0), 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.mst_ws && bus.mst_dat == 8'h75) && n < 100);
    chk(5, "reached_read_step2", 64'(bus.mst_ws), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_reset(5);
    rst = 1'b0;
    send(1'b1, DEV, 8'h00, 8'h00, mk(6, 8'h11, 2'd0, 4, 48'({K_SW, K_WRTE, K_SW, K_RNS})), 1'b1, 1'b0, 1'b0);
    drain(6);

    // T6 back-to-back writes with req_valid held high, then read-back
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'(8'h11 * (i + 1));
      send(1'b0, DEV, 8'(i), d, mk(10 + i, 8'h00, 2'd0, 3, 48'({K_SW, K_WRTE, K_WS})),
           1'b1, (i != 7), (i != 0));
    end
    drain(17);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'(8'h11 * (i + 1));
      send(1'b1, DEV, 8'(i), 8'h00, mk(20 + i, d, 2'd0, 4, 48'({K_SW, K_WRTE, K_SW, K_RNS})),
           1'b1, 1'b0, 1'b0);
    end
    drain(27);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
